bc_clr_en_reg_sched: RTL and testbench

- Scheduler that shares one bank of NUM_REG clear/enable DFF registers among NUM_REQ requesters.
- Arbitrates write and clear requests round-robin and drives per-register registered enable/clear strobes plus a shared write-data bus.
- Provides a sequenced clear-all operation that clears the bank one register per cycle.
- Sits between bus/CSR masters and the register bank.

---
 rtl/bc_clr_en_reg_sched.sv | 158 +++++++++++++++
 tb/tb_bc_clr_en_reg_sched.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/bc_clr_en_reg_sched.sv
// Round-robin scheduler sharing one bank of clear/enable registers among several requesters,
// with a sequenced clear-all that sweeps the bank one register per cycle.
module bc_clr_en_reg_sched #(
    parameter int NUM_REQ = 4,
    parameter int NUM_REG = 8,
    parameter int WIDTH   = 32,
    parameter int AW      = $clog2(NUM_REG),
    parameter int RW      = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       iReqVld,
    input  logic [NUM_REQ-1:0]       iReqClr,
    input  logic [NUM_REQ*AW-1:0]    iReqAddr,
    input  logic [NUM_REQ*WIDTH-1:0] iReqDat,
    output logic [NUM_REQ-1:0]       oReqRdy,
    input  logic                     iClrAll,
    output logic                     oClrAllBusy,
    output logic [NUM_REG-1:0]       oRegEn,
    output logic [NUM_REG-1:0]       oRegClr,
    output logic [WIDTH-1:0]         oRegDat,
    output logic [RW-1:0]            oGntIdx,
    output logic                     oAddrErr
);

    localparam int CW = $clog2(NUM_REG + 1);

    typedef enum logic {IDLE, CLRALL} state_t;

    state_t             state_q, state_d;
    logic [RW-1:0]      rr_q, rr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [NUM_REG-1:0] en_q, en_d;
    logic [NUM_REG-1:0] clr_q, clr_d;
    logic [WIDTH-1:0]   dat_q, dat_d;
    logic [RW-1:0]      gnt_q, gnt_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;

    logic [2*NUM_REQ-1:0] vld_rot;
    logic                 win_vld;
    logic [RW-1:0]        win_idx;
    int                   win_sum;
    logic                 grant;
    logic [AW-1:0]        win_addr;
    logic [WIDTH-1:0]     win_dat;
    logic                 win_clr;

    // Rotate the valid vector so the search always starts at bit 0 = rr pointer.
    always_comb begin
        vld_rot = {iReqVld, iReqVld} >> rr_q;
        win_vld = 1'b0;
        win_idx = '0;
        win_sum = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_vld && vld_rot[i]) begin
                win_vld = 1'b1;
                win_sum = int'(rr_q) + i;
                if (win_sum >= NUM_REQ)
                    win_sum = win_sum - NUM_REQ;
                win_idx = RW'(win_sum);
            end
        end
    end

    always_comb begin
        win_addr = '0;
        win_dat  = '0;
        win_clr  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win_idx == RW'(k)) begin
                win_addr = iReqAddr[k*AW +: AW];
                win_dat  = iReqDat[k*WIDTH +: WIDTH];
                win_clr  = iReqClr[k];
            end
        end
    end

    assign grant   = (state_q == IDLE) && !iClrAll && win_vld;
    assign oReqRdy = grant ? (NUM_REQ'(1) << win_idx) : '0;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        en_d    = '0;
        clr_d   = '0;
        dat_d   = dat_q;
        gnt_d   = gnt_q;
        err_d   = 1'b0;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (iClrAll) begin
                    // The entry edge already issues the strobe for register 0.
                    state_d = CLRALL;
                    busy_d  = 1'b1;
                    clr_d   = NUM_REG'(1);
                    cnt_d   = CW'(1);
                end else if (win_vld) begin
                    rr_d  = (win_idx == RW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
                    gnt_d = win_idx;
                    if (int'(win_addr) >= NUM_REG) begin
                        err_d = 1'b1;
                    end else if (win_clr) begin
                        clr_d = NUM_REG'(1) << win_addr;
                    end else begin
                        en_d  = NUM_REG'(1) << win_addr;
                        dat_d = win_dat;
                    end
                end
            end
            CLRALL: begin
                if (cnt_q == CW'(NUM_REG)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end else begin
                    clr_d = NUM_REG'(1) << cnt_q;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            rr_q    <= '0;
            cnt_q   <= '0;
            en_q    <= '0;
            clr_q   <= '0;
            dat_q   <= '0;
            gnt_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            clr_q   <= clr_d;
            dat_q   <= dat_d;
            gnt_q   <= gnt_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign oRegEn      = en_q;
    assign oRegClr     = clr_q;
    assign oRegDat     = dat_q;
    assign oGntIdx     = gnt_q;
    assign oAddrErr    = err_q;
    assign oClrAllBusy = busy_q;

endmodule

// File: tb/tb_bc_clr_en_reg_sched.sv
// Scoreboard bench for bc_clr_en_reg_sched: directed scenarios then random traffic,
// checked against a cycle-level behavioural model of the scheduling rules.
module tb_bc_clr_en_reg_sched;

    localparam int NQ = 4;
    localparam int NR = 6;
    localparam int W  = 32;
    localparam int AW = 3;
    localparam int RW = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [NQ-1:0]    req_vld;
    logic [NQ-1:0]    req_clr;
    logic [NQ*AW-1:0] req_addr;
    logic [NQ*W-1:0]  req_dat;
    logic [NQ-1:0]    rdy;
    logic             clr_all;
    logic             busy;
    logic [NR-1:0]    reg_en;
    logic [NR-1:0]    reg_clr;
    logic [W-1:0]     reg_dat;
    logic [RW-1:0]    gnt_idx;
    logic             addr_err;

    bc_clr_en_reg_sched #(.NUM_REQ(NQ), .NUM_REG(NR), .WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .iReqVld(req_vld), .iReqClr(req_clr), .iReqAddr(req_addr), .iReqDat(req_dat),
        .oReqRdy(rdy), .iClrAll(clr_all), .oClrAllBusy(busy),
        .oRegEn(reg_en), .oRegClr(reg_clr), .oRegDat(reg_dat),
        .oGntIdx(gnt_idx), .oAddrErr(addr_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic          chk_rdy;
        logic [NQ-1:0] rdy;
        logic [NR-1:0] en;
        logic [NR-1:0] clr;
        logic [W-1:0]  dat;
        logic [RW-1:0] gnt;
        logic          err;
        logic          busy;
    } exp_t;

    exp_t exp_q[$];

    // Model state: m_pos is the register whose clear-all strobe is on the outputs (-1 = not sweeping)
    int           m_pos = -1;
    int           m_rr  = 0;
    int           m_gnt = 0;
    logic [W-1:0] m_dat = '0;
    int           last_w = -1;

    task automatic step(input logic r, input logic ca);
        exp_t e;
        int   w;
        int   a;
        rst     = r;
        clr_all = ca;
        w = -1;
        if (r && m_pos < 0 && !ca)
            for (int i = 0; i < NQ; i++)
                if (w < 0 && req_vld[(m_rr + i) % NQ]) w = (m_rr + i) % NQ;
        e.chk_rdy = r;
        e.rdy = '0;
        if (w >= 0) e.rdy[w] = 1'b1;
        e.en  = '0;
        e.clr = '0;
        e.err = 1'b0;
        if (!r) begin
            m_pos = -1; m_rr = 0; m_gnt = 0; m_dat = '0;
        end else if (m_pos >= 0) begin
            if (m_pos == NR - 1) m_pos = -1;
            else begin
                m_pos++;
                e.clr[m_pos] = 1'b1;
            end
        end else if (ca) begin
            m_pos = 0;
            e.clr[0] = 1'b1;
        end else if (w >= 0) begin
            a = int'(req_addr[w*AW +: AW]);
            m_rr  = (w + 1) % NQ;
            m_gnt = w;
            if (a >= NR) e.err = 1'b1;
            else if (req_clr[w]) e.clr[a] = 1'b1;
            else begin
                e.en[a] = 1'b1;
                m_dat = req_dat[w*W +: W];
            end
        end
        e.busy = (m_pos >= 0);
        e.dat  = m_dat;
        e.gnt  = RW'(m_gnt);
        exp_q.push_back(e);
        last_w = w;
    endtask

    // Called at a negedge with inputs set; returns at the next negedge with the accepted request dropped.
    task automatic tick(input logic r, input logic ca);
        step(r, ca);
        @(negedge clk);
        if (last_w >= 0) req_vld[last_w] = 1'b0;
    endtask

    task automatic set_req(input int k, input logic c, input int a, input logic [W-1:0] d);
        req_vld[k] = 1'b1;
        req_clr[k] = c;
        req_addr[k*AW +: AW] = AW'(a);
        req_dat[k*W +: W] = d;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() == 0) continue;
            e = exp_q[0];
            if (e.chk_rdy) check("oReqRdy", 64'(rdy), 64'(e.rdy));
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            check("oRegEn", 64'(reg_en), 64'(e.en));
            check("oRegClr", 64'(reg_clr), 64'(e.clr));
            check("oRegDat", 64'(reg_dat), 64'(e.dat));
            check("oGntIdx", 64'(gnt_idx), 64'(e.gnt));
            check("oAddrErr", 64'(addr_err), 64'(e.err));
            check("oClrAllBusy", 64'(busy), 64'(e.busy));
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1);
    end

    initial begin : driver
        rst = 1'b0; clr_all = 1'b0;
        req_vld = '0; req_clr = '0; req_addr = '0; req_dat = '0;
        @(negedge clk);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        check("reset_en", 64'(reg_en), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);

        // Single write from requester 1
        set_req(1, 1'b0, 3, 32'hDEADBEEF);
        tick(1'b1, 1'b0);
        check("dir_wr_en", 64'(reg_en), 64'h08);
        check("dir_wr_dat", 64'(reg_dat), 64'hDEADBEEF);
        check("dir_wr_gnt", 64'(gnt_idx), 64'd1);

        // Clear from requester 2 leaves data untouched
        set_req(2, 1'b1, 5, 32'h12345678);
        tick(1'b1, 1'b0);
        check("dir_clr", 64'(reg_clr), 64'h20);
        check("dir_clr_dat", 64'(reg_dat), 64'hDEADBEEF);
        tick(1'b1, 1'b0);

        // Pointer back to 0, then all requesters continuously valid
        tick(1'b0, 1'b0);
        for (int c = 0; c < 8; c++) begin
            for (int k = 0; k < NQ; k++)
                if (!req_vld[k]) set_req(k, 1'b0, (k + c) % NR, $urandom);
            tick(1'b1, 1'b0);
        end
        req_vld = '0;
        tick(1'b1, 1'b0);

        // Clear-all pulse colliding with a request from requester 0
        set_req(0, 1'b0, 2, 32'hA5A5A5A5);
        tick(1'b1, 1'b1);
        for (int c = 0; c < NR + 2; c++) tick(1'b1, 1'b0);

        // Reset during the third clear-all strobe
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        check("midrst_clr", 64'(reg_clr), 64'd0);
        for (int c = 0; c < 3; c++) tick(1'b1, 1'b0);

        // Out-of-range address, then the next grant starts at requester 1
        set_req(0, 1'b0, 7, 32'h0BADF00D);
        tick(1'b1, 1'b0);
        check("dir_err", 64'(addr_err), 64'd1);
        set_req(0, 1'b0, 1, 32'h11111111);
        set_req(1, 1'b0, 2, 32'h22222222);
        tick(1'b1, 1'b0);
        check("dir_after_err_gnt", 64'(gnt_idx), 64'd1);
        req_vld = '0;
        tick(1'b1, 1'b0);

        // Clear-all held as a level: sweeps restart back to back
        for (int c = 0; c < 2 * NR + 3; c++) tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);
        for (int c = 0; c < NR + 1; c++) tick(1'b1, 1'b0);

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < NQ; k++)
                if (!req_vld[k] && ($urandom_range(0, 1) == 1))
                    set_req(k, ($urandom_range(0, 3) == 0), $urandom_range(0, 7), $urandom);
            tick(($urandom_range(0, 99) != 0), ($urandom_range(0, 24) == 0));
        end
        req_vld = '0;
        tick(1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
